// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: widths, opcode field position, fetch FSM states.
package legv8_pkg;

  localparam int          INSTR_W_DEF  = 32;
  localparam int          OPCODE_MSB   = 31;
  localparam int          OPCODE_LSB   = 21;
  localparam int          OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for an instruction that arrived while decode was stalled.
module fetch_hold_buf #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               resetl,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               vld,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  // Clear/drain empty the entry; load captures a new word.
  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear || drain) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d   = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
    end
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign vld   = vld_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, instruction-memory req/ack handshake, redirect flush and stall skid.
module instruction_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                CLK,
  input  logic                resetl,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  input  logic                stall,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [OPCODE_W-1:0] opcode
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  flush_addr_q, flush_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;

  logic               hb_load, hb_drain, hb_clear, hb_vld;
  logic [INSTR_W-1:0] hb_instr;
  logic [ADDR_W-1:0]  hb_pc;

  logic               slot_free;
  logic [ADDR_W-1:0]  tgt, pc_inc;

  assign slot_free = !if_valid_q || !stall;
  assign tgt       = redirect_target & ~ADDR_W'(3);
  assign pc_inc    = pc_q + ADDR_W'(4);

  fetch_hold_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_hold (
    .clk     (CLK),
    .resetl  (resetl),
    .load    (hb_load),
    .drain   (hb_drain),
    .clear   (hb_clear),
    .d_instr (imem_rdata),
    .d_pc    (pc_q),
    .vld     (hb_vld),
    .instr   (hb_instr),
    .pc      (hb_pc)
  );

  // Next-state: redirect beats ack and stall; an unstalled live beat is consumed.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    if_valid_d   = if_valid_q && stall;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    hb_load      = 1'b0;
    hb_drain     = 1'b0;
    hb_clear     = 1'b0;

    if (redirect_valid) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      hb_clear   = 1'b1;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          // Without an ack the old request is still in flight: keep it up, drop its data.
          if (!imem_ack) begin
            flush_addr_d = pc_q;
            state_d      = FLUSH;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
          end else begin
            hb_load = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (!stall) begin
          if_valid_d = hb_vld;
          if_instr_d = hb_instr;
          if_pc_d    = hb_pc;
          hb_drain   = 1'b1;
          state_d    = REQ;
        end
      end
      FLUSH: begin
        if_valid_d = 1'b0;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    imem_req_d  = (state_d == REQ) || (state_d == FLUSH);
    imem_addr_d = (state_d == FLUSH) ? flush_addr_d : pc_d;
  end

  // FSM, PC, output slot and registered memory request.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      flush_addr_q <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign opcode    = if_instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: the expected instruction stream is the architectural PC sequence
// (start at reset PC, +4 per instruction, restart at an aligned target on redirect),
// with each word taken from a fixed memory image function of its address.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [10:0] opcode;

  instruction_fetch_unit dut (
    .CLK(CLK), .resetl(resetl), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .opcode(opcode)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] next_pc;
  int          total = 0;
  int          bad = 0;
  int          beats = 0;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h8B020020;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [63:0] pc);
    exp_q.delete();
    next_pc = pc;
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: next_pc, instr: memf(next_pc)});
      next_pc = next_pc + 64'd4;
    end
  endtask

  // One cycle of stimulus; memory acks only an outstanding request, returning the image word.
  task automatic cycle(input bit a, input bit s, input bit r, input logic [63:0] t, input bit rn);
    @(posedge CLK); #1;
    resetl          = rn;
    imem_ack        = a & imem_req;
    imem_rdata      = (a & imem_req) ? memf(imem_addr) : $urandom;
    stall           = s;
    redirect_valid  = r;
    redirect_target = t;
    if (!rn) restart(64'h0);
    else if (r) restart(t & ~64'd3);
    refill();
  endtask

  // Monitor: protocol rules from the previous cycle, and pops the scoreboard on each consumed beat.
  logic        p_rst = 1'b1, p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_stall = 1'b0, p_redir = 1'b0;
  logic [63:0] p_addr = '0, p_pc = '0;
  logic [31:0] p_instr = '0;
  always @(negedge CLK) begin
    exp_t e;
    if (!p_rst) begin
      chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
      chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
      chk("rst_opcode", {53'd0, opcode}, 64'd0);
      chk("rst_if_pc", if_pc, 64'd0);
    end else begin
      if (p_req && !p_ack) begin
        chk("req_held", {63'd0, imem_req}, 64'd1);
        chk("addr_stable", imem_addr, p_addr);
      end
      if (p_valid && p_stall && !p_redir) begin
        chk("stall_valid", {63'd0, if_valid}, 64'd1);
        chk("stall_instr", {32'd0, if_instr}, {32'd0, p_instr});
        chk("stall_pc", if_pc, p_pc);
      end
      if (p_req && p_ack && p_valid && p_stall && !p_redir)
        chk("hold_req_low", {63'd0, imem_req}, 64'd0);
      if (p_redir) chk("redirect_kill", {63'd0, if_valid}, 64'd0);
    end
    if (resetl && if_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL beat_unexpected pc=%h", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("beat_pc", if_pc, e.pc);
        chk("beat_instr", {32'd0, if_instr}, {32'd0, e.instr});
        chk("beat_opcode", {53'd0, opcode}, {53'd0, e.instr[31:21]});
        beats++;
      end
    end
    p_rst = resetl; p_req = imem_req; p_ack = imem_ack; p_valid = if_valid;
    p_stall = stall; p_redir = redirect_valid; p_addr = imem_addr;
    p_pc = if_pc; p_instr = if_instr;
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin cycle(0, 0, 0, 64'd0, 1); n++; end
    chk("wait_req_timeout", {63'd0, imem_req}, 64'd1);
  endtask

  initial begin
    restart(64'h0);
    refill();
    // Reset held two cycles, then release.
    cycle(0, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 1);
    cycle(0, 0, 0, 64'd0, 1);
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h0);

    // Zero-wait stream: one instruction per cycle.
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0, 64'd0, 1);
      if (i >= 2) chk("zero_wait_valid", {63'd0, if_valid}, 64'd1);
    end

    // Stall with ack: word goes to the skid, request drops, then drains.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 64'd0, 1);
    chk("pre_hold_valid", {63'd0, if_valid}, 64'd1);
    cycle(1, 1, 0, 64'd0, 1);
    cycle(0, 1, 0, 64'd0, 1);
    chk("hold_no_req", {63'd0, imem_req}, 64'd0);
    cycle(0, 1, 0, 64'd0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 64'd0, 1);

    // Flush in flight: redirect with no ack keeps old request, then refetch from aligned target.
    wait_req();
    cycle(0, 0, 1, 64'h43, 1);
    cycle(0, 0, 0, 64'd0, 1);
    cycle(0, 0, 0, 64'd0, 1);
    cycle(1, 0, 0, 64'd0, 1);
    cycle(0, 0, 0, 64'd0, 1);
    chk("flush_refetch_req", {63'd0, imem_req}, 64'd1);
    chk("flush_refetch_addr", imem_addr, 64'h40);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 64'd0, 1);

    // Redirect + ack + stall in one cycle.
    cycle(1, 1, 0, 64'd0, 1);
    wait_req();
    cycle(1, 1, 1, 64'h80, 1);
    cycle(0, 0, 0, 64'd0, 1);
    chk("r6_valid", {63'd0, if_valid}, 64'd0);
    chk("r6_addr", imem_addr, 64'h80);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 64'd0, 1);

    // PC wrap at the top of the address space.
    cycle(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 64'd0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit a, s, r, rn;
      logic [63:0] t;
      a  = ($urandom_range(0, 99) < 60);
      s  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 4);
      rn = ($urandom_range(0, 999) >= 3);
      t  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {48'd0, 16'($urandom)};
      cycle(a, s, r, t, rn);
    end
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 64'd0, 1);

    total++;
    if (beats < 300) begin
      bad++;
      $display("FAIL delivered_beats actual=%0d required>=300", beats);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
